// File: rtl/posit_quire_to_pd.sv
// Quire-to-posit-denormalized converter. Takes a two's-complement fixed-point quire,
// finds its leading one with an iterative chunked scan and emits the sign / zero / NaR /
// scale / fraction / guard / round / sticky fields for the downstream normalize-round stage.
// Optional: define QUIRE_TO_PD_SAT_FLAG_EN to add the pd_sat output (scale was clamped).
module posit_quire_to_pd #(
  parameter int unsigned POSIT_WIDTH    = 32,
  parameter int unsigned POSIT_ES       = 2,
  parameter int unsigned QUIRE_WIDTH    = 512,
  parameter int unsigned QUIRE_FRAC     = 240,
  parameter int unsigned SCALE_WIDTH    = 9,
  parameter int unsigned FRACTION_WIDTH = 27,
  // Must divide QUIRE_WIDTH.
  parameter int unsigned CHUNK          = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          q_valid,
  output logic                          q_ready,
  input  logic [QUIRE_WIDTH-1:0]        q_data,
  input  logic                          q_NaR,
  output logic                          pd_valid,
  input  logic                          pd_ready,
  output logic                          pd_sign,
  output logic                          pd_zero,
  output logic                          pd_NaR,
  output logic signed [SCALE_WIDTH-1:0] pd_scale,
  output logic [FRACTION_WIDTH-1:0]     pd_fraction,
`ifdef QUIRE_TO_PD_SAT_FLAG_EN
  output logic                          pd_sat,
`endif
  output logic                          pd_guard,
  output logic                          pd_round,
  output logic                          pd_sticky
);

  localparam int LzW      = $clog2(QUIRE_WIDTH) + 1;
  localparam int SW       = $clog2(QUIRE_WIDTH) + 2;  // holds +/-QUIRE_WIDTH
  localparam int PW       = (CHUNK > 1) ? $clog2(CHUNK) : 1;
  localparam int TopScale = int'(QUIRE_WIDTH) - 1 - int'(QUIRE_FRAC);
  localparam int MaxS     = (int'(POSIT_WIDTH) - 2) * (1 << POSIT_ES);

  localparam logic signed [SW-1:0] TopScaleV = SW'(TopScale);
  localparam logic signed [SW-1:0] MaxSV     = SW'(MaxS);
  localparam logic signed [SW-1:0] MinSV     = SW'(-MaxS);

  typedef enum logic [1:0] {StIdle, StAbs, StScan, StEmit} state_e;

  state_e state_q, state_d;

  logic [QUIRE_WIDTH-1:0]        mag_q;
  logic [LzW-1:0]                lz_q;
  logic                          sign_q;

  logic                          sign_out_q;
  logic                          zero_q;
  logic                          nar_q;
  logic signed [SCALE_WIDTH-1:0] scale_q;
  logic [FRACTION_WIDTH-1:0]     frac_q;
  logic                          guard_q;
  logic                          round_q;
  logic                          sticky_q;

  logic [CHUNK-1:0]              top_chunk;
  logic [PW-1:0]                 lead_p;
  logic [QUIRE_WIDTH-1:0]        norm;
  logic [LzW-1:0]                lz_total;
  logic signed [SW-1:0]          scale_full;
  logic                          sat_hi;
  logic                          sat_lo;
  logic                          is_special;

  assign top_chunk  = mag_q[QUIRE_WIDTH-1 -: CHUNK];
  assign is_special = q_NaR || (q_data == '0);

  // Position of the leading one inside the top chunk; last hit wins so the highest bit rules.
  always_comb begin
    lead_p = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      if (top_chunk[i]) lead_p = PW'(int'(CHUNK) - 1 - i);
    end
  end

  assign norm       = mag_q << lead_p;
  assign lz_total   = lz_q + LzW'(lead_p);
  assign scale_full = TopScaleV - $signed({1'b0, lz_total});
  assign sat_hi     = scale_full > MaxSV;
  assign sat_lo     = scale_full < MinSV;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (q_valid) state_d = is_special ? StEmit : StAbs;
      StAbs:   state_d = StScan;
      StScan:  if (top_chunk != '0) state_d = StEmit;
      StEmit:  if (pd_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: capture, magnitude, coarse scan and final field registration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q      <= '0;
      lz_q       <= '0;
      sign_q     <= 1'b0;
      sign_out_q <= 1'b0;
      zero_q     <= 1'b0;
      nar_q      <= 1'b0;
      scale_q    <= '0;
      frac_q     <= '0;
      guard_q    <= 1'b0;
      round_q    <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (q_valid) begin
            mag_q  <= q_data;
            sign_q <= q_data[QUIRE_WIDTH-1];
            lz_q   <= '0;
            if (is_special) begin
              sign_out_q <= 1'b0;
              nar_q      <= q_NaR;
              zero_q     <= ~q_NaR;
              scale_q    <= '0;
              frac_q     <= '0;
              guard_q    <= 1'b0;
              round_q    <= 1'b0;
              sticky_q   <= 1'b0;
            end
          end
        end
        StAbs: begin
          // Unsigned negation: the most negative quire maps to 2^(QUIRE_WIDTH-1).
          mag_q <= sign_q ? (~mag_q + QUIRE_WIDTH'(1)) : mag_q;
          lz_q  <= '0;
        end
        StScan: begin
          if (top_chunk == '0) begin
            mag_q <= mag_q << CHUNK;
            lz_q  <= lz_q + LzW'(CHUNK);
          end else begin
            sign_out_q <= sign_q;
            zero_q     <= 1'b0;
            nar_q      <= 1'b0;
            if (sat_hi || sat_lo) begin
              scale_q  <= sat_hi ? SCALE_WIDTH'(MaxSV) : SCALE_WIDTH'(MinSV);
              frac_q   <= '0;
              guard_q  <= 1'b0;
              round_q  <= 1'b0;
              sticky_q <= 1'b0;
            end else begin
              scale_q  <= SCALE_WIDTH'(scale_full);
              frac_q   <= norm[QUIRE_WIDTH-2 -: FRACTION_WIDTH];
              guard_q  <= norm[QUIRE_WIDTH-2-FRACTION_WIDTH];
              round_q  <= norm[QUIRE_WIDTH-3-FRACTION_WIDTH];
              sticky_q <= |norm[QUIRE_WIDTH-4-FRACTION_WIDTH:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef QUIRE_TO_PD_SAT_FLAG_EN
  logic sat_q;

  // Clamp flag, loaded alongside the other fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if (state_q == StIdle && q_valid) begin
      sat_q <= 1'b0;
    end else if (state_q == StScan && top_chunk != '0) begin
      sat_q <= sat_hi || sat_lo;
    end
  end

  assign pd_sat = sat_q;
`endif

  assign q_ready     = (state_q == StIdle);
  assign pd_valid    = (state_q == StEmit);
  assign pd_sign     = sign_out_q;
  assign pd_zero     = zero_q;
  assign pd_NaR      = nar_q;
  assign pd_scale    = scale_q;
  assign pd_fraction = frac_q;
  assign pd_guard    = guard_q;
  assign pd_round    = round_q;
  assign pd_sticky   = sticky_q;

endmodule

// File: doc/posit_quire_to_pd.md
Name: posit_quire_to_pd

Overview:
- Multi-cycle converter from a two's-complement fixed-point quire (accumulator) value to the denormalized posit field set: sign, zero, NaR, scale, fraction, guard/round/sticky.
- Sits directly upstream of the posit normalize/round stage and feeds its pd slave fields.
- Uses an iterative chunked leading-zero scan, which keeps area small for wide quires.
- Valid/ready handshake on both sides; one conversion in flight at a time.

Parameters:
- POSIT_WIDTH, 32, target posit width.
- POSIT_ES, 2, target exponent size.
- QUIRE_WIDTH, 512, quire width in bits (two's complement).
- QUIRE_FRAC, 240, number of quire bits below the binary point.
- SCALE_WIDTH, 9, signed scale width driven to the pd fields.
- FRACTION_WIDTH, 27, fraction bits after the hidden one.
- CHUNK, 8, coarse scan shift per cycle. Must divide QUIRE_WIDTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- q_valid  in  1  quire word valid
- q_ready  out  1  converter can accept a word
- q_data  in  QUIRE_WIDTH  quire value, two's complement
- q_NaR  in  1  quire holds NaR
- pd_valid  out  1  pd fields valid
- pd_ready  in  1  downstream accepts
- pd_sign  out  1  sign
- pd_zero  out  1  value is zero
- pd_NaR  out  1  value is NaR
- pd_scale  out  SCALE_WIDTH  signed scale (2^scale)
- pd_fraction  out  FRACTION_WIDTH  fraction, hidden bit removed
- pd_guard / pd_round / pd_sticky  out  1 each  rounding bits below the fraction

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset: state IDLE; q_ready=1; pd_valid=0; all pd_* fields=0.
- Reset asserted mid-operation aborts the conversion with no output.
- FSM states: IDLE, ABS, SCAN, EMIT.
- IDLE:
  - q_ready=1.
  - On q_valid&q_ready (cycle T), capture q_data, q_NaR and sign=q_data[MSB].
  - If q_NaR: go to EMIT with NaR=1, all other fields 0.
  - Else if q_data==0: go to EMIT with zero=1, all other fields 0. q_NaR has priority over zero.
  - Else go to ABS.
- ABS (cycle T+1):
  - Register the magnitude (negate if sign=1); clear lz.
  - The most negative quire value yields magnitude 2^(QUIRE_WIDTH-1), handled unsigned.
  - Go to SCAN.
- SCAN:
  - If the top CHUNK bits are all 0: shift left by CHUNK, lz+=CHUNK.
  - Otherwise, in the same cycle: priority-encode the top chunk giving p, shift left by p, lz+=p, compute fields, go to EMIT.
- Field computation:
  - scale = (QUIRE_WIDTH-1-QUIRE_FRAC) - lz, in signed arithmetic wide enough to hold ±QUIRE_WIDTH.
  - fraction = the FRACTION_WIDTH bits below the leading one.
  - guard and round = the next two bits.
  - sticky = OR of all remaining lower bits.
- Saturation, with MAXS = (POSIT_WIDTH-2)*2^POSIT_ES:
  - If scale > MAXS: scale=MAXS; fraction, guard, round, sticky all 0.
  - If scale < -MAXS: scale=-MAXS; fraction, guard, round, sticky all 0.
  - The downstream stage therefore yields maxpos/minpos, never NaR or zero.
- EMIT:
  - pd_valid=1; fields held stable while pd_ready=0.
  - On pd_valid&pd_ready: go to IDLE. q_ready returns on the next cycle (no same-cycle turnaround).
- Latency from acceptance at T:
  - NaR/zero: pd_valid at T+1.
  - Nonzero: pd_valid at T+3+floor(lz/CHUNK).
- Throughput: q_ready=0 in every state except IDLE.

Optional Feature:
- Macro QUIRE_TO_PD_SAT_FLAG_EN.
- Defined: adds output port pd_sat (1 bit), registered with the other fields. pd_sat=1 when scale was clamped, valid while pd_valid=1; reset 0.
- Undefined: port absent; clamping behaviour is identical.

Test Plan:
All cases use default parameters.
- 1.0 (only bit 240 set), accepted at T -> pd_valid at T+36; sign=0, scale=0, fraction=0, G=R=S=0.
- -1.5 (two's complement of bits 240|239) -> sign=1, scale=0, fraction MSB=1 and other bits 0, G=R=S=0.
- 1+2^-240 (bits 240 and 0) -> scale=0, fraction=0, guard=0, round=0, sticky=1.
- Bit 510 set -> scale=120, fraction=0, GRS=0 (pd_sat=1 with the macro). Bit 0 set -> scale=-120, fraction=0, GRS=0 (pd_sat=1).
- q_NaR=1 with q_data=0 -> pd_valid at T+1, NaR=1, zero=0. q_data=0 -> zero=1. Hold pd_ready=0 for 5 cycles -> fields stable and q_ready=0 throughout; after the handshake, q_ready=1 on the next cycle.
- rst_n pulsed low during SCAN -> pd_valid=0 immediately, q_ready=1. A subsequent 1.0 converts correctly with no residue from the aborted conversion.
